demux1_2_stream: RTL and testbench
==================================

# demux1_2_stream

Buffered 1-to-2 stream demultiplexer: the routing counterpart of the 2:1 select mux. Steers each accepted input word to output A (`in_sel`=0) or output B (`in_sel`=1), matching the mux convention S=0 selects A. Each output has its own FIFO so a stalled consumer does not block traffic to the other output. It sits between a single producer (e.g., a decode or writeback source) and two independent consumers.

## Interface
- `WIDTH`, 16, data word width in bits
- `DEPTH`, 2, entries per output FIFO; power of 2, minimum 2
- `clk` input 1 system clock; all state updates on rising edge
- `rst` input 1 synchronous, active-high reset
- `in_data` input WIDTH word to route
- `in_sel` input 1 destination: 0 = A, 1 = B
- `in_valid` input 1 producer offers `in_data`/`in_sel`
- `in_ready` output 1 selected destination FIFO can accept
- `outA_data` output WIDTH head of FIFO A; 0 when A is empty
- `outA_valid` output 1 FIFO A non-empty
- `outA_ready` input 1 consumer A takes the head this cycle
- `outB_data`, `outB_valid`, `outB_ready`: same as A, for FIFO B
- `cntA` output 16 words accepted toward A; see Configuration
- `cntB` output 16 words accepted toward B; see Configuration

## Operation
- Each FIFO has a write pointer, a read pointer (log2(DEPTH) bits, wrap modulo DEPTH), and an occupancy count (log2(DEPTH)+1 bits, range 0..DEPTH).
- `in_ready` = NOT full(FIFO[`in_sel`]). It is combinational on `in_sel` and on registered occupancy only. There is no path from `outX_ready` to `in_ready`.
- Input transfer: `in_valid` & `in_ready` at a rising edge. `in_data` is written at the selected FIFO's write pointer, which then increments.
- Output transfer: `outX_valid` & `outX_ready` at a rising edge. The read pointer increments.
- `outX_ready` while `outX_valid`=0 has no effect.
- Simultaneous enqueue and dequeue on the same FIFO: occupancy is unchanged and both pointers advance.
- Full FIFO with a dequeue in the same cycle: no enqueue occurs (`in_ready` is already 0). The FIFO frees an entry for the next cycle.
- Order is preserved per output. There is no ordering relationship between A and B.
- `in_sel` and `in_data` are ignored when `in_valid`=0. Words are never dropped or duplicated.

## Timing
- Reset: both FIFOs are empty and pointers are 0.
  - `outA_valid`=`outB_valid`=0; `outA_data`=`outB_data`=0.
  - `in_ready`=1; `cntA`=`cntB`=0.
- `rst` asserted mid-operation discards all buffered words at that edge. Handshakes in the same cycle as `rst` are ignored.
- Latency: a word accepted at edge N shows up on `outX_data` with `outX_valid`=1 in cycle N+1 (one cycle, no bypass).
- Throughput: one input word per cycle while the target FIFO is not full. Each output can sustain one word per cycle.
- A FIFO that has been full reopens one cycle after its first dequeue: dequeue at edge N gives `in_ready`=1 for that destination in cycle N+1.
- Output data is taken from the FIFO memory at the read pointer and gated to 0 when empty. It is stable while `outX_valid`=1 and `outX_ready`=0.

## Configuration
- `DEMUX_COUNT_EN` defined:
  - `cntA`/`cntB` each increment by 1 on every input transfer to their destination.
  - They saturate at 16'hFFFF and clear on `rst`.
- `DEMUX_COUNT_EN` undefined: no counter registers; `cntA`/`cntB` are tied to 0. Routing behaviour is identical either way.

## Test plan
- Route: after reset, send 16'h1111 with sel=0 and 16'h2222 with sel=1 on consecutive cycles, both outputs ready. Required response:
  - `outA_valid` is high for one cycle with 16'h1111 in the cycle after acceptance.
  - `outB` shows 16'h2222 one cycle later.
  - `cntA`=`cntB`=1 (with macro).
- Isolation: hold `outA_ready`=0 and push 3 words to A (DEPTH=2). Required response:
  - The third word sees `in_ready`=0.
  - A word with sel=1 is still accepted and appears on B.
- Full with simultaneous dequeue: A is full and `outA_ready`=1 with `in_valid`, sel=0 in the same cycle. Required response:
  - No enqueue that cycle; A holds 1 word.
  - `in_ready`=1 next cycle; order is preserved (head sequence 1, 2, 3).
- Wrap-around: stream 10 words 0..9 to B with `outB_ready`=1 throughout. Required response: B emits 0..9 in order, one per cycle after a 1-cycle latency, with no gaps.
- Mid-operation reset: A holds 2 words when `rst` is pulsed for 1 cycle. Required response:
  - Next cycle `outA_valid`=0, `outA_data`=0, `in_ready`=1, `cntA`=0.
- Counter saturation (macro defined): force 65,537 transfers to A. Required response: `cntA`=16'hFFFF and `cntB`=0.

Source files
------------

// File: rtl/demux1_2_stream.sv
// ----------------------------------------------------------------------------
// demux1_2_stream
//
// Buffered 1-to-2 stream demultiplexer. Each accepted input word goes to
// output A (in_sel = 0) or output B (in_sel = 1). Each output has its own
// FIFO, so a stalled consumer on one side does not block traffic to the other.
//
// Parameters:
//   WIDTH  data word width in bits
//   DEPTH  entries per output FIFO (power of 2, minimum 2)
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_data/in_sel        word to route and its destination (0 = A, 1 = B)
//   in_valid/in_ready     producer handshake; ready = selected FIFO not full
//   outA_data/valid/ready consumer A handshake (data is 0 while A is empty)
//   outB_data/valid/ready consumer B handshake (data is 0 while B is empty)
//   cntA, cntB            saturating counts of words accepted toward A / B
//
// Optional feature macro: DEMUX_COUNT_EN
//   defined   -> cntA/cntB are 16-bit saturating counters cleared by rst
//   undefined -> no counter registers; cntA/cntB are tied to 0
// ----------------------------------------------------------------------------

// Single-clock FIFO used for each output of the demultiplexer.
module demux1_2_stream_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop_ready,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop;

    assign valid = (count_q != '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = valid & pop_ready;

    // Head word is gated to zero while empty so stale memory never leaks out.
    assign rdata = valid ? mem_q[rd_ptr_q] : '0;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only observed through the gated head.
    // A push during a reset cycle leaves no visible trace since count clears.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module demux1_2_stream #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] outA_data,
    output logic             outA_valid,
    input  logic             outA_ready,
    output logic [WIDTH-1:0] outB_data,
    output logic             outB_valid,
    input  logic             outB_ready,
    output logic [15:0]      cntA,
    output logic [15:0]      cntB
);
    logic full_a, full_b;
    logic push_a, push_b;

    // Ready depends only on the selected FIFO's registered occupancy, never on
    // the consumer ready inputs, so no combinational path crosses the block.
    assign in_ready = in_sel ? ~full_b : ~full_a;
    assign push_a   = in_valid & in_ready & ~in_sel;
    assign push_b   = in_valid & in_ready &  in_sel;

    demux1_2_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (push_a),
        .wdata     (in_data),
        .pop_ready (outA_ready),
        .full      (full_a),
        .valid     (outA_valid),
        .rdata     (outA_data)
    );

    demux1_2_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (push_b),
        .wdata     (in_data),
        .pop_ready (outB_ready),
        .full      (full_b),
        .valid     (outB_valid),
        .rdata     (outB_data)
    );

`ifdef DEMUX_COUNT_EN
    logic [15:0] cnt_a_q, cnt_a_d;
    logic [15:0] cnt_b_q, cnt_b_d;

    // Counters stick at all-ones instead of wrapping back to zero.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (push_a && (cnt_a_q != 16'hFFFF)) begin
            cnt_a_d = cnt_a_q + 16'd1;
        end
        if (push_b && (cnt_b_q != 16'hFFFF)) begin
            cnt_b_d = cnt_b_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cntA = cnt_a_q;
    assign cntB = cnt_b_q;
`else
    assign cntA = '0;
    assign cntB = '0;
`endif
endmodule

// File: tb/tb_demux1_2_stream.sv
// ----------------------------------------------------------------------------
// tb_demux1_2_stream
//
// Directed and randomized bench for demux1_2_stream. A transaction-level model
// keeps one queue of expected words per output; a monitor compares the DUT
// outputs against the model on every falling edge.
// ----------------------------------------------------------------------------
module tb_demux1_2_stream;
    localparam int WIDTH = 16;
    localparam int DEPTH = 2;
`ifdef DEMUX_COUNT_EN
    localparam bit CountEn = 1'b1;
`else
    localparam bit CountEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] outA_data;
    logic             outA_valid;
    logic             outA_ready;
    logic [WIDTH-1:0] outB_data;
    logic             outB_valid;
    logic             outB_ready;
    logic [15:0]      cntA;
    logic [15:0]      cntB;

    int checks = 0;
    int errors = 0;
    bit monEn  = 1'b0;

    logic [WIDTH-1:0] expA[$];
    logic [WIDTH-1:0] expB[$];
    int cntModelA = 0;
    int cntModelB = 0;

    demux1_2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .outA_data  (outA_data),
        .outA_valid (outA_valid),
        .outA_ready (outA_ready),
        .outB_data  (outB_data),
        .outB_valid (outB_valid),
        .outB_ready (outB_ready),
        .cntA       (cntA),
        .cntB       (cntB)
    );

    always #5 clk = ~clk;

    // Compare one observed value against the expected value and tally it.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge, then wait for the next edge.
    task automatic applyStimulus(input bit v, input bit s, input logic [WIDTH-1:0] d,
                                 input bit ra, input bit rb);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        outA_ready = ra;
        outB_ready = rb;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] expCount(input int n);
        if (!CountEn) return 16'h0000;
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    // Reference model: a word is accepted whenever its destination holds fewer
    // than DEPTH words; a consumer takes the head whenever it is ready and the
    // destination holds anything. Reset empties everything and ignores handshakes.
    always @(posedge clk) begin : model
        int szA;
        int szB;
        szA = expA.size();
        szB = expB.size();
        if (rst) begin
            expA.delete();
            expB.delete();
            cntModelA = 0;
            cntModelB = 0;
        end else begin
            if (outA_ready && szA > 0) void'(expA.pop_front());
            if (outB_ready && szB > 0) void'(expB.pop_front());
            if (in_valid) begin
                if (!in_sel && szA < DEPTH) begin
                    expA.push_back(in_data);
                    cntModelA++;
                end else if (in_sel && szB < DEPTH) begin
                    expB.push_back(in_data);
                    cntModelB++;
                end
            end
        end
    end

    // Monitor: every DUT output is held against the model mid-cycle.
    always @(negedge clk) begin
        if (monEn) begin
            checkOutput("outA_valid", 32'(outA_valid), 32'(expA.size() > 0));
            checkOutput("outA_data", 32'(outA_data), (expA.size() > 0) ? 32'(expA[0]) : 32'h0);
            checkOutput("outB_valid", 32'(outB_valid), 32'(expB.size() > 0));
            checkOutput("outB_data", 32'(outB_data), (expB.size() > 0) ? 32'(expB[0]) : 32'h0);
            checkOutput("in_ready", 32'(in_ready),
                        32'((in_sel ? expB.size() : expA.size()) < DEPTH));
            checkOutput("cntA", 32'(cntA), 32'(expCount(cntModelA)));
            checkOutput("cntB", 32'(cntB), 32'(expCount(cntModelB)));
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        outA_ready = 1'b0; outB_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst   = 1'b0;
        monEn = 1'b1;

        // Reset state
        checkOutput("rst_outA_valid", 32'(outA_valid), 32'h0);
        checkOutput("rst_outB_valid", 32'(outB_valid), 32'h0);
        checkOutput("rst_outA_data", 32'(outA_data), 32'h0);
        checkOutput("rst_outB_data", 32'(outB_data), 32'h0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
        checkOutput("rst_cntA", 32'(cntA), 32'h0);

        // Route: one word to each side on consecutive cycles
        applyStimulus(1, 0, 16'h1111, 1, 1);
        checkOutput("route_A_data", 32'(outA_data), 32'h1111);
        applyStimulus(1, 1, 16'h2222, 1, 1);
        checkOutput("route_A_gone", 32'(outA_valid), 32'h0);
        checkOutput("route_B_data", 32'(outB_data), 32'h2222);
        applyStimulus(0, 0, 16'h0000, 1, 1);
        checkOutput("route_cntA", 32'(cntA), 32'(CountEn ? 1 : 0));
        checkOutput("route_cntB", 32'(cntB), 32'(CountEn ? 1 : 0));

        // Isolation: A stalled and full, B still flows
        applyStimulus(1, 0, 16'hA001, 0, 1);
        applyStimulus(1, 0, 16'hA002, 0, 1);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hA003;
        #1;
        checkOutput("iso_third_in_ready", 32'(in_ready), 32'h0);
        applyStimulus(1, 0, 16'hA003, 0, 1);
        applyStimulus(1, 1, 16'hB001, 0, 1);
        checkOutput("iso_B_data", 32'(outB_data), 32'hB001);

        // Full with simultaneous dequeue: no enqueue, reopens next cycle
        applyStimulus(1, 0, 16'h0003, 1, 1);
        checkOutput("fulldq_A_head", 32'(outA_data), 32'hA002);
        applyStimulus(1, 0, 16'h0003, 0, 1);
        applyStimulus(0, 0, 16'h0000, 1, 1);
        applyStimulus(0, 0, 16'h0000, 1, 1);
        applyStimulus(0, 0, 16'h0000, 1, 1);

        // Wrap-around: 10 words streamed through B
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 16'(i), 1, 1);
        applyStimulus(0, 0, 16'h0000, 1, 1);

        // Mid-operation reset with a handshake in the reset cycle
        applyStimulus(1, 0, 16'hAAAA, 0, 0);
        applyStimulus(1, 0, 16'hAAAB, 0, 0);
        rst = 1'b1;
        applyStimulus(1, 0, 16'hBBBB, 1, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("midrst_outA_valid", 32'(outA_valid), 32'h0);
        checkOutput("midrst_outA_data", 32'(outA_data), 32'h0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'h1);
        checkOutput("midrst_cntA", 32'(cntA), 32'h0);
        @(posedge clk); #1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end

`ifdef DEMUX_COUNT_EN
        // Saturation: enough transfers to A to pass the counter ceiling
        rst = 1'b1;
        applyStimulus(0, 0, 16'h0000, 1, 1);
        rst = 1'b0;
        for (int i = 0; i < 65537; i++) applyStimulus(1, 0, 16'(i), 1, 1);
        checkOutput("sat_cntA", 32'(cntA), 32'hFFFF);
        checkOutput("sat_cntB", 32'(cntB), 32'h0);
`endif

        // Drain and confirm nothing is left behind
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 16'h0000, 1, 1);
        checkOutput("drain_outA_valid", 32'(outA_valid), 32'h0);
        checkOutput("drain_outB_valid", 32'(outB_valid), 32'h0);

        monEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
